serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (D = A - B), LSB first, one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0]    cnt;
  logic             brw, diff, brw_nxt, last, load;

  assign diff    = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  assign last    = (cnt == CW'(WIDTH - 1));

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (Start) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (last) state_nxt = DONE;
      DONE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (state == SHIFT && last) begin
      // the final difference bit is the result MSB
      Ovf <= (a_msb != b_msb) && (diff != a_msb);
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      D    <= '0;
      Bout <= 1'b0;
    end else if (load) begin
      a_sr <= A;
      b_sr <= B;
      cnt  <= '0;
      brw  <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      res  <= {diff, res[WIDTH-1:1]};
      brw  <= brw_nxt;
      cnt  <= cnt + 1'b1;
      // result register is still one bit short here, so publish the shifted value
      if (last) begin
        D    <= {diff, res[WIDTH-1:1]};
        Bout <= brw_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, back-to-back, reset abort, random sweep.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Rst, Start;
  logic [WIDTH-1:0] A, B, D;
  logic             Busy, Done, Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             Ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] last_d;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .D(D), .Bout(Bout)
`ifdef SERIAL_SUB_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge just after the accepting edge; returns on the Done negedge.
  task automatic wait_done(input logic [7:0] ea, input logic [7:0] eb);
    int n = 1;
    int sd;
    while (Done !== 1'b1 && n <= 20) begin
      chk("busy", Busy, 1);
      chk("hold", D, last_d);
      @(negedge Clk);
      n++;
    end
    chk("latency", n, WIDTH + 1);
    chk("done", Done, 1);
    chk("busy_at_done", Busy, 0);
    chk("d", D, 32'((int'(ea) - int'(eb)) & 255));
    chk("bout", Bout, (ea < eb) ? 1 : 0);
`ifdef SERIAL_SUB_OVF_EN
    sd = int'($signed(ea)) - int'($signed(eb));
    chk("ovf", Ovf, (sd > 127 || sd < -128) ? 1 : 0);
`else
    sd = 0;
`endif
    last_d = 8'((int'(ea) - int'(eb)) & 255);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b);
    A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    wait_done(a, b);
    @(negedge Clk);
    chk("done_pulse", Done, 0);
    chk("d_after", D, last_d);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b1; A = 8'h5A; B = 8'h23;
    last_d = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_d", D, 0);
    chk("rst_bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", Ovf, 0);
`endif
    Rst = 1'b0; Start = 1'b0;
    @(negedge Clk);

    op(8'h5A, 8'h23);
    op(8'h10, 8'h20);
    op(8'h80, 8'h01);
    op(8'h00, 8'h00);
    op(8'h00, 8'h01);
    op(8'hFF, 8'hFF);
    op(8'h7F, 8'h80);

    // Start held through SHIFT with new operands; second op launches on Done
    A = 8'h5A; B = 8'h23; Start = 1'b1;
    @(negedge Clk);
    A = 8'h11; B = 8'h99;
    wait_done(8'h5A, 8'h23);
    @(negedge Clk);
    Start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    wait_done(8'h11, 8'h99);
    @(negedge Clk);
    chk("b2b_done_pulse", Done, 0);

    // Reset in the middle of SHIFT aborts with no Done
    A = 8'hC3; B = 8'h3C; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_d", D, 0);
    chk("abort_bout", Bout, 0);
    last_d = '0;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge Clk);
        if (Done === 1'b1) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    op(8'hC3, 8'h3C);

    for (int i = 0; i < 1000; i++) op(8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
